// File: rtl/mmio_router_if.sv
// rtl/mmio_router_if.sv - CPU data port and per-slave bus bundle for the MMIO router.
interface mmio_router_if #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int NUM_SLV = 2
);
    logic                      cpu_mem_req;
    logic                      cpu_mem_we;
    logic [ADDR_W-1:0]         cpu_mem_addr;
    logic [XLEN-1:0]           cpu_mem_wdata;
    logic [XLEN-1:0]           cpu_mem_rdata;
    logic                      cpu_mem_ready;
    logic                      cpu_mem_err;
    logic [NUM_SLV-1:0]        slv_req;
    logic [NUM_SLV-1:0]        slv_we;
    logic [NUM_SLV*ADDR_W-1:0] slv_addr;
    logic [NUM_SLV*XLEN-1:0]   slv_wdata;
    logic [NUM_SLV*XLEN-1:0]   slv_rdata;
    logic [NUM_SLV-1:0]        slv_ready;

    // Environment side: the CPU drives requests, the slaves drive responses.
    modport master (
        output cpu_mem_req, cpu_mem_we, cpu_mem_addr, cpu_mem_wdata,
        input  cpu_mem_rdata, cpu_mem_ready, cpu_mem_err,
        input  slv_req, slv_we, slv_addr, slv_wdata,
        output slv_rdata, slv_ready
    );

    // Router side.
    modport slave (
        input  cpu_mem_req, cpu_mem_we, cpu_mem_addr, cpu_mem_wdata,
        output cpu_mem_rdata, cpu_mem_ready, cpu_mem_err,
        output slv_req, slv_we, slv_addr, slv_wdata,
        input  slv_rdata, slv_ready
    );
endinterface

// File: rtl/mmio_router.sv
// rtl/mmio_router.sv - Base/mask address router from the CPU data port to NUM_SLV slaves.
module mmio_router #(
    parameter int                        XLEN      = 32,
    parameter int                        ADDR_W    = 32,
    parameter int                        NUM_SLV   = 2,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE  = {32'h4000_0000, 32'h0000_0000},
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK  = {32'hFFFF_F000, 32'hFFFF_0000},
    parameter int                        TIMEOUT   = 255,
    parameter logic [XLEN-1:0]           ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              rst,
    mmio_router_if.slave      bus,
    input  logic              err_clr,
    output logic              err_sticky,
    output logic [ADDR_W-1:0] err_addr
);
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                    state, nxt_state;
    logic                      lat_we;
    logic [ADDR_W-1:0]         lat_addr;
    logic [XLEN-1:0]           lat_wdata;
    logic [NUM_SLV-1:0]        lat_sel;
    logic [CNT_W-1:0]          cnt, nxt_cnt;

    logic [NUM_SLV-1:0]        dec_sel;
    logic                      cur_we;
    logic [ADDR_W-1:0]         cur_addr;
    logic [XLEN-1:0]           cur_wdata;
    logic [NUM_SLV-1:0]        cur_sel;
    logic [XLEN-1:0]           sel_rdata;
    logic                      act_ready;
    logic                      nxt_ready;
    logic                      nxt_err;
    logic [XLEN-1:0]           nxt_rdata;
    logic                      set_err;
    logic [NUM_SLV-1:0]        nxt_slv_req;
    logic [NUM_SLV-1:0]        nxt_slv_we;
    logic [NUM_SLV*ADDR_W-1:0] nxt_slv_addr;
    logic [NUM_SLV*XLEN-1:0]   nxt_slv_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            lat_we            <= 1'b0;
            lat_addr          <= '0;
            lat_wdata         <= '0;
            lat_sel           <= '0;
            cnt               <= '0;
            bus.cpu_mem_ready <= 1'b0;
            bus.cpu_mem_err   <= 1'b0;
            bus.cpu_mem_rdata <= '0;
            bus.slv_req       <= '0;
            bus.slv_we        <= '0;
            bus.slv_addr      <= '0;
            bus.slv_wdata     <= '0;
            err_sticky        <= 1'b0;
            err_addr          <= '0;
        end else begin
            state <= nxt_state;
            if (state == IDLE && bus.cpu_mem_req) begin
                lat_we    <= bus.cpu_mem_we;
                lat_addr  <= bus.cpu_mem_addr;
                lat_wdata <= bus.cpu_mem_wdata;
                lat_sel   <= dec_sel;
            end
            cnt               <= nxt_cnt;
            bus.cpu_mem_ready <= nxt_ready;
            bus.cpu_mem_err   <= nxt_err;
            bus.cpu_mem_rdata <= nxt_rdata;
            bus.slv_req       <= nxt_slv_req;
            bus.slv_we        <= nxt_slv_we;
            bus.slv_addr      <= nxt_slv_addr;
            bus.slv_wdata     <= nxt_slv_wdata;
            // A new error outranks a clear arriving in the same cycle.
            if (set_err) begin
                err_sticky <= 1'b1;
                err_addr   <= cur_addr;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

    always_comb begin
        nxt_state     = state;
        nxt_cnt       = cnt;
        nxt_ready     = 1'b0;
        nxt_err       = bus.cpu_mem_err;
        nxt_rdata     = bus.cpu_mem_rdata;
        cur_we        = lat_we;
        cur_addr      = lat_addr;
        cur_wdata     = lat_wdata;
        cur_sel       = lat_sel;
        dec_sel       = '0;
        sel_rdata     = '0;
        nxt_slv_req   = '0;
        nxt_slv_we    = '0;
        nxt_slv_addr  = '0;
        nxt_slv_wdata = '0;

        // Descending scan so the lowest matching index is the one left standing.
        for (int k = NUM_SLV - 1; k >= 0; k--) begin
            if ((bus.cpu_mem_addr & SLV_MASK[k*ADDR_W +: ADDR_W]) == SLV_BASE[k*ADDR_W +: ADDR_W]) begin
                dec_sel    = '0;
                dec_sel[k] = 1'b1;
            end
        end
        for (int k = 0; k < NUM_SLV; k++) begin
            if (lat_sel[k]) sel_rdata = bus.slv_rdata[k*XLEN +: XLEN];
        end
        act_ready = |(bus.slv_ready & lat_sel);

        case (state)
            IDLE: begin
                cur_we    = bus.cpu_mem_we;
                cur_addr  = bus.cpu_mem_addr;
                cur_wdata = bus.cpu_mem_wdata;
                cur_sel   = dec_sel;
                if (bus.cpu_mem_req) begin
                    if (|dec_sel) begin
                        nxt_state = ACCESS;
                        nxt_cnt   = '0;
                    end else begin
                        nxt_state = RESP;
                        nxt_ready = 1'b1;
                        nxt_err   = 1'b1;
                        nxt_rdata = ERR_RDATA;
                    end
                end
            end
            ACCESS: begin
                nxt_cnt = cnt + 1'b1;
                if (act_ready) begin
                    nxt_state = RESP;
                    nxt_ready = 1'b1;
                    nxt_err   = 1'b0;
                    nxt_rdata = lat_we ? '0 : sel_rdata;
                end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                    nxt_state = RESP;
                    nxt_ready = 1'b1;
                    nxt_err   = 1'b1;
                    nxt_rdata = ERR_RDATA;
                end
            end
            RESP:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase

        // Slave-side outputs are registered from the state being entered.
        if (nxt_state == ACCESS) begin
            for (int k = 0; k < NUM_SLV; k++) begin
                if (cur_sel[k]) begin
                    nxt_slv_req[k]                  = 1'b1;
                    nxt_slv_we[k]                   = cur_we;
                    nxt_slv_addr[k*ADDR_W +: ADDR_W] = cur_addr;
                    nxt_slv_wdata[k*XLEN +: XLEN]    = cur_wdata;
                end
            end
        end
        set_err = nxt_ready & nxt_err;
    end
endmodule

// File: tb/tb_mmio_router.sv
// tb/tb_mmio_router.sv - Directed scoreboard bench for mmio_router.
module tb_mmio_router;
    logic        clk = 1'b0;
    logic        rst;
    logic        err_clr;
    logic        es0, es1;
    logic [31:0] ea0, ea1;

    always #5 clk = ~clk;

    mmio_router_if #(.XLEN(32), .ADDR_W(32), .NUM_SLV(2)) bus0 ();
    mmio_router_if #(.XLEN(32), .ADDR_W(32), .NUM_SLV(2)) bus1 ();

    mmio_router #(.TIMEOUT(4)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .err_clr(err_clr),
        .err_sticky(es0), .err_addr(ea0)
    );

    // Slave1 covers the whole space, overlapping slave0.
    mmio_router #(
        .SLV_BASE(64'h0),
        .SLV_MASK({32'h0000_0000, 32'hFFFF_0000}),
        .TIMEOUT(4)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .err_clr(err_clr),
        .err_sticky(es1), .err_addr(ea1)
    );

    assign bus1.cpu_mem_req   = bus0.cpu_mem_req;
    assign bus1.cpu_mem_we    = bus0.cpu_mem_we;
    assign bus1.cpu_mem_addr  = bus0.cpu_mem_addr;
    assign bus1.cpu_mem_wdata = bus0.cpu_mem_wdata;
    assign bus1.slv_rdata     = bus0.slv_rdata;
    assign bus1.slv_ready     = bus0.slv_ready;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t sb[$];
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [1:0] sel, input int lat, input logic [31:0] srdata,
                             input logic [31:0] exp_rdata, input logic exp_err,
                             input int exp_req_cycles, input int exp_ready_cycle, input bit ovl);
        resp_t       r;
        int          req_cycles  = 0;
        int          ready_cycle = 0;
        logic [63:0] ea          = '0;
        logic [63:0] ew          = '0;
        logic [1:0]  ewe         = '0;
        for (int k = 0; k < 2; k++) begin
            if (sel[k]) begin
                ea[k*32 +: 32] = addr;
                ew[k*32 +: 32] = wdata;
                ewe[k]         = we;
            end
        end
        r.rdata = exp_rdata;
        r.err   = exp_err;
        sb.push_back(r);
        @(posedge clk); #1;
        bus0.cpu_mem_req   = 1'b1;
        bus0.cpu_mem_we    = we;
        bus0.cpu_mem_addr  = addr;
        bus0.cpu_mem_wdata = wdata;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (bus0.cpu_mem_ready) begin
                ready_cycle = c;
                break;
            end
            if (bus0.slv_req != 2'b00) begin
                req_cycles++;
                chk("slv_req", bus0.slv_req, sel);
                chk("slv_we", bus0.slv_we, ewe);
                chk("slv_addr", bus0.slv_addr, ea);
                chk("slv_wdata", bus0.slv_wdata, ew);
                if (ovl) chk("ovl_slv_req", bus1.slv_req, sel);
            end
            if (c == 1) begin
                bus0.cpu_mem_we    = ~we;
                bus0.cpu_mem_addr  = 32'h8000_0000;
                bus0.cpu_mem_wdata = ~wdata;
            end
            bus0.slv_ready = (c == lat) ? sel : 2'b00;
            bus0.slv_rdata = sel[1] ? {srdata, 32'hBADB_AD00} : {32'hBADB_AD11, srdata};
        end
        chk("ready_cycle", ready_cycle, exp_ready_cycle);
        chk("req_cycles", req_cycles, exp_req_cycles);
        if (ready_cycle != 0) begin
            r = sb.pop_front();
            chk("rdata", bus0.cpu_mem_rdata, r.rdata);
            chk("err", bus0.cpu_mem_err, r.err);
            chk("slv_req_in_resp", bus0.slv_req, 2'b00);
        end else if (sb.size() != 0) begin
            r = sb.pop_front();
        end
        bus0.cpu_mem_req = 1'b0;
        bus0.slv_ready   = 2'b00;
        @(posedge clk); #1;
        chk("ready_pulse", bus0.cpu_mem_ready, 1'b0);
    endtask

    initial begin
        rst                = 1'b1;
        err_clr            = 1'b0;
        bus0.cpu_mem_req   = 1'b0;
        bus0.cpu_mem_we    = 1'b0;
        bus0.cpu_mem_addr  = '0;
        bus0.cpu_mem_wdata = '0;
        bus0.slv_rdata     = '0;
        bus0.slv_ready     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_slv_req", bus0.slv_req, 2'b00);
        chk("rst_slv_we", bus0.slv_we, 2'b00);
        chk("rst_slv_addr", bus0.slv_addr, 64'h0);
        chk("rst_slv_wdata", bus0.slv_wdata, 64'h0);
        chk("rst_ready", bus0.cpu_mem_ready, 1'b0);
        chk("rst_err", bus0.cpu_mem_err, 1'b0);
        chk("rst_rdata", bus0.cpu_mem_rdata, 32'h0);
        chk("rst_sticky", es0, 1'b0);
        chk("rst_err_addr", ea0, 32'h0);
        rst = 1'b0;

        // Overlapping map, minimum latency.
        do_access(1'b0, 32'h0000_0000, 32'h0, 2'b01, 1, 32'h0BAD_F00D,
                  32'h0BAD_F00D, 1'b0, 1, 2, 1'b1);
        do_access(1'b0, 32'h0000_0104, 32'h0, 2'b01, 2, 32'h1234_5678,
                  32'h1234_5678, 1'b0, 2, 3, 1'b0);
        do_access(1'b1, 32'h4000_0010, 32'hA5A5_0001, 2'b10, 3, 32'h7777_7777,
                  32'h0, 1'b0, 3, 4, 1'b0);
        chk("sticky_clean", es0, 1'b0);
        do_access(1'b0, 32'h8000_0000, 32'h0, 2'b00, 0, 32'h0,
                  32'hDEAD_BEEF, 1'b1, 0, 1, 1'b0);
        chk("sticky_unmapped", es0, 1'b1);
        chk("err_addr_unmapped", ea0, 32'h8000_0000);

        do_access(1'b0, 32'h4000_0020, 32'h0, 2'b10, -1, 32'h0,
                  32'hDEAD_BEEF, 1'b1, 4, 5, 1'b0);
        chk("sticky_timeout", es0, 1'b1);
        chk("err_addr_timeout", ea0, 32'h4000_0020);
        bus0.slv_ready = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("late_ready_ignored", bus0.cpu_mem_ready, 1'b0);
            chk("late_ready_no_req", bus0.slv_req, 2'b00);
        end
        bus0.slv_ready = 2'b00;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("sticky_cleared", es0, 1'b0);
        chk("err_addr_kept", ea0, 32'h4000_0020);

        // Reset in the middle of an access.
        @(posedge clk); #1;
        bus0.cpu_mem_req  = 1'b1;
        bus0.cpu_mem_we   = 1'b0;
        bus0.cpu_mem_addr = 32'h0000_0200;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_req", bus0.slv_req, 2'b01);
        rst = 1'b1;
        #1;
        chk("mid_rst_slv_req", bus0.slv_req, 2'b00);
        chk("mid_rst_slv_addr", bus0.slv_addr, 64'h0);
        chk("mid_rst_ready", bus0.cpu_mem_ready, 1'b0);
        chk("mid_rst_rdata", bus0.cpu_mem_rdata, 32'h0);
        chk("mid_rst_err", bus0.cpu_mem_err, 1'b0);
        chk("mid_rst_err_addr", ea0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus0.cpu_mem_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_resp", bus0.cpu_mem_ready, 1'b0);
        end
        do_access(1'b0, 32'h0000_0300, 32'h0, 2'b01, 1, 32'hCAFE_0300,
                  32'hCAFE_0300, 1'b0, 1, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
